game_state_ctrl: RTL

- Top-level game sequencer for the scoring and lives datapath.
- Sequences the game through attract, play, death/respawn, wave-clear and game-over phases.
- Generates the synchronous clear pulse for the score/lives register block and the freeze, respawn and wave-advance controls for the entity logic.
- Sits between the input/collision logic and the renderer; consumes the current lives/score and frame ticks.

---
 rtl/game_state_ctrl_pkg.sv | 24 ++
 rtl/game_state_ctrl_frame_timer.sv | 34 +++
 rtl/game_state_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/game_state_ctrl_pkg.sv
// Shared constants for the game sequencer: state encodings, default phase
// lengths in frame ticks, wave saturation and the starting life count.
package game_state_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_ATTRACT    = 3'd0,
        ST_PLAYING    = 3'd1,
        ST_DEAD       = 3'd2,
        ST_WAVE_CLEAR = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_t;

    localparam int DEF_DEATH_FRAMES    = 90;
    localparam int DEF_WAVE_FRAMES     = 120;
    localparam int DEF_GAMEOVER_FRAMES = 240;
    localparam int MAX_WAVE            = 15;
    localparam int PLAYER_LIVES        = 3;

    // States whose duration is measured in frame ticks.
    function automatic logic is_timed(input state_t s);
        return (s == ST_DEAD) || (s == ST_WAVE_CLEAR) || (s == ST_GAME_OVER);
    endfunction

endpackage

// File: rtl/game_state_ctrl_frame_timer.sv
// 8-bit clearable frame counter; done flags the tick that completes `limit_i`
// frames. Clear has priority so a tick on the clearing cycle is discarded.
module frame_timer (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       clr_i,
    input  logic       tick_i,
    input  logic [7:0] limit_i,
    output logic       done_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = tick_i && (count_q == (limit_i - 8'd1));

endmodule

// File: rtl/game_state_ctrl.sv
// Game phase sequencer: attract, play, death/respawn, wave-clear, game-over.
// Define HIGH_SCORE_EN to build the high-score register; otherwise high_score is 0.
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int DEATH_FRAMES    = game_state_ctrl_pkg::DEF_DEATH_FRAMES,
    parameter int WAVE_FRAMES     = game_state_ctrl_pkg::DEF_WAVE_FRAMES,
    parameter int GAMEOVER_FRAMES = game_state_ctrl_pkg::DEF_GAMEOVER_FRAMES,
    parameter int MAX_WAVE        = game_state_ctrl_pkg::MAX_WAVE
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       start_btn,
    input  logic       frame_tick,
    input  logic       player_collision,
    input  logic       invaders_landed,
    input  logic       wave_clear,
    input  logic [1:0] lives,
    input  logic [6:0] score,
    output logic [2:0] state,
    output logic       score_rst,
    output logic       freeze,
    output logic       respawn,
    output logic       wave_next,
    output logic [3:0] wave_num,
    output logic [6:0] high_score
);

    state_t     state_q, state_d;
    logic       score_rst_q, score_rst_d;
    logic       respawn_q, respawn_d;
    logic       wave_next_q, wave_next_d;
    logic       freeze_q;
    logic [3:0] wave_num_q, wave_num_d;

    logic       timer_clr;
    logic       timer_tick;
    logic       timer_done;
    logic [7:0] timer_limit;

    always_comb begin
        timer_limit = 8'(DEATH_FRAMES);
        case (state_q)
            ST_WAVE_CLEAR: timer_limit = 8'(WAVE_FRAMES);
            ST_GAME_OVER:  timer_limit = 8'(GAMEOVER_FRAMES);
            default:       timer_limit = 8'(DEATH_FRAMES);
        endcase
    end

    // Any state change (or an untimed state) restarts the count from zero.
    assign timer_tick = frame_tick && is_timed(state_q);
    assign timer_clr  = (state_d != state_q) || !is_timed(state_q);

    frame_timer u_frame_timer (
        .clk     (clk),
        .arst_n  (arst_n),
        .clr_i   (timer_clr),
        .tick_i  (timer_tick),
        .limit_i (timer_limit),
        .done_o  (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        score_rst_d = 1'b0;
        respawn_d   = 1'b0;
        wave_next_d = 1'b0;
        wave_num_d  = wave_num_q;
        case (state_q)
            ST_ATTRACT: begin
                wave_num_d = '0;
                if (start_btn) begin
                    state_d     = ST_PLAYING;
                    score_rst_d = 1'b1;
                    wave_next_d = 1'b1;
                    respawn_d   = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (invaders_landed) begin
                    state_d = ST_GAME_OVER;
                end else if (player_collision) begin
                    state_d = ST_DEAD;
                end else if (wave_clear) begin
                    state_d = ST_WAVE_CLEAR;
                end
            end
            ST_DEAD: begin
                // lives is sampled here rather than at the collision so the
                // decrement in the score/lives block has already landed.
                if (timer_done) begin
                    if (lives == 2'd0) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d   = ST_PLAYING;
                        respawn_d = 1'b1;
                    end
                end
            end
            ST_WAVE_CLEAR: begin
                if (timer_done) begin
                    state_d     = ST_PLAYING;
                    wave_next_d = 1'b1;
                    respawn_d   = 1'b1;
                    if (wave_num_q < 4'(MAX_WAVE)) begin
                        wave_num_d = wave_num_q + 4'd1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start_btn) begin
                    state_d     = ST_PLAYING;
                    score_rst_d = 1'b1;
                    wave_next_d = 1'b1;
                    respawn_d   = 1'b1;
                    wave_num_d  = '0;
                end else if (timer_done) begin
                    state_d = ST_ATTRACT;
                end
            end
            default: begin
                state_d = ST_ATTRACT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_ATTRACT;
            score_rst_q <= 1'b0;
            respawn_q   <= 1'b0;
            wave_next_q <= 1'b0;
            freeze_q    <= 1'b1;
            wave_num_q  <= '0;
        end else begin
            state_q     <= state_d;
            score_rst_q <= score_rst_d;
            respawn_q   <= respawn_d;
            wave_next_q <= wave_next_d;
            freeze_q    <= (state_d != ST_PLAYING);
            wave_num_q  <= wave_num_d;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [6:0] high_score_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            high_score_q <= '0;
        end else if ((state_d == ST_GAME_OVER) && (state_q != ST_GAME_OVER)
                     && (score > high_score_q)) begin
            high_score_q <= score;
        end
    end

    assign high_score = high_score_q;
`else
    logic score_unused;
    assign score_unused = ^score;
    assign high_score   = '0;
`endif

    assign state     = state_q;
    assign score_rst = score_rst_q;
    assign respawn   = respawn_q;
    assign wave_next = wave_next_q;
    assign freeze    = freeze_q;
    assign wave_num  = wave_num_q;

endmodule
